// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer: size codes,
// FSM state encodings and small helpers used by the request path.
package mips_mem_pkg;

  // Access size code carried by MemReadM / MemWriteM / MemSize
  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Byte lanes in a 32-bit memory word
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // True when the low address bits do not match the natural alignment of the size
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return |addr_lo;
      SZ_HALF: return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // Store data arrives low-aligned; copy it onto every lane so the memory
  // can pick the lane from the address without a shifter of its own.
  function automatic logic [31:0] lane_replicate(input size_e size, input logic [31:0] data);
    case (size)
      SZ_HALF: return {2{data[15:0]}};
      SZ_BYTE: return {4{data[7:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data alignment: picks the addressed byte/half lane out of
// the memory word and sign-extends it to 32 bits. Words pass straight through.
module load_aligner
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  size_e       i_size,
  output logic [31:0] o_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] w_lanes;
  logic [LANE_W-1:0]                w_byte;
  logic [2*LANE_W-1:0]              w_half;

  assign w_lanes = i_rdata;
  assign w_byte  = w_lanes[i_addr_lo];
  // half lane is chosen by addr[1] alone; addr[0] is zero for legal halves
  assign w_half  = i_addr_lo[1] ? {w_lanes[3], w_lanes[2]} : {w_lanes[1], w_lanes[0]};

  // Size-dependent sign extension of the selected lane
  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_HALF: o_data = {{16{w_half[15]}}, w_half};
      SZ_BYTE: o_data = {{24{w_byte[7]}}, w_byte};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer: launches one req/ack data-memory access per load/store
// sitting in EX/MEM, freezes the front of the pipeline while it is in flight,
// returns aligned load data, flags bad or timed-out accesses and drives the
// branch/jal flush for the front end.
module mem_stage_controller
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        MemWriteM,
  input  logic [1:0]        MemReadM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] RData2M,
  input  logic              BranchM,
  input  logic              ZeroM,
  input  logic              JalM,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData,
  output logic              MemReq,
  output logic              MemWe,
  output logic [1:0]        MemSize,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              StallOut,
  output logic              BubbleWB,
  output logic [DATA_W-1:0] LoadData,
  output logic              LoadValid,
  output logic              FlushOut,
  output logic              MemErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req, r_we, r_lvalid, r_err;
  size_e               r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_ldata;

  logic                w_rd, w_wr, w_access, w_illegal, w_misal;
  size_e               w_size;
  logic                w_start, w_bad, w_ack_hit, w_cnt_hit, w_abort, w_stall;
  logic [31:0]         w_aligned;

  // Decode of the instruction currently held in EX/MEM
  assign w_rd      = |MemReadM;
  assign w_wr      = |MemWriteM;
  assign w_access  = w_rd ^ w_wr;
  assign w_illegal = w_rd & w_wr;
  assign w_size    = size_e'(w_rd ? MemReadM : MemWriteM);
  assign w_misal   = w_access & is_misaligned(w_size, ALUResultM[1:0]);

  // Only IDLE looks at EX/MEM: DONE still holds the finished instruction
  assign w_start   = (r_state == ST_IDLE) & w_access & ~w_misal;
  assign w_bad     = (r_state == ST_IDLE) & (w_illegal | w_misal);

  // Ack wins over a timeout landing in the same cycle; acks elsewhere are ignored
  assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ack_hit = (r_state == ST_ACCESS) & MemAck;
  assign w_abort   = (r_state == ST_ACCESS) & ~MemAck & w_cnt_hit;

  // Sequencer state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and pipeline stall
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_ACCESS;
          w_stall     = 1'b1;
        end
      end
      ST_ACCESS: begin
        w_stall = 1'b1;
        if (MemAck || w_cnt_hit) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Cycles spent waiting in ACCESS, restarted on every launch
  always_ff @(posedge Clk) begin
    if (Reset)                       r_cnt <= '0;
    else if (w_start)                r_cnt <= '0;
    else if (r_state == ST_ACCESS)   r_cnt <= r_cnt + 1'b1;
  end

  // Request registers: captured at launch, MemReq held until ack or abort
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= SZ_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= w_wr;
      r_size  <= w_size;
      r_addr  <= (w_size == SZ_WORD) ? {ALUResultM[ADDR_W-1:2], 2'b00} : ALUResultM;
      r_wdata <= w_wr ? lane_replicate(w_size, RData2M) : '0;
    end else if (w_ack_hit || w_abort) begin
      r_req   <= 1'b0;
    end
  end

  // Request attributes are stable through ACCESS, so they steer the aligner
  load_aligner u_align (
    .i_rdata   (MemRData),
    .i_addr_lo (r_addr[1:0]),
    .i_size    (r_size),
    .o_data    (w_aligned)
  );

  // Load result and its one-cycle valid pulse (a timed-out load returns zero)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ldata  <= '0;
      r_lvalid <= 1'b0;
    end else begin
      r_lvalid <= (w_ack_hit | w_abort) & ~r_we;
      if (w_ack_hit && !r_we)     r_ldata <= w_aligned;
      else if (w_abort && !r_we)  r_ldata <= '0;
    end
  end

  // Sticky error: illegal, misaligned or timed-out access
  always_ff @(posedge Clk) begin
    if (Reset)                   r_err <= 1'b0;
    else if (w_bad || w_abort)   r_err <= 1'b1;
  end

  assign MemReq    = r_req;
  assign MemWe     = r_we;
  assign MemSize   = r_size;
  assign MemAddr   = r_addr;
  assign MemWData  = r_wdata;
  assign LoadData  = r_ldata;
  assign LoadValid = r_lvalid;
  assign MemErr    = r_err;
  assign StallOut  = w_stall;
  assign BubbleWB  = w_stall;
  // A frozen EX/MEM must not redirect the front end yet
  assign FlushOut  = ((BranchM & ZeroM) | JalM) & ~w_stall;

endmodule
